mem_bus_arbiter: RTL

Shares the single memory bus between three cache-side requesters: ICache line refill, DCache line refill and DCache dirty-line writeback. Sits between the ICache/DCache miss FSMs and the memory bridge. Only one burst is in flight at a time. Read data is steered to the requester that owns the grant.

---
 rtl/mem_bus_arbiter_pkg.sv | 22 ++
 rtl/mem_bus_arbiter_rd_pick.sv | 37 +++
 rtl/mem_bus_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: FSM states, grant-id codes and line
// geometry shared by the arbiter and the cache miss FSMs.
package mem_bus_arbiter_pkg;

  localparam int LINE_WORDS = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_DATA = 3'd4,
    WR_RESP = 3'd5
  } arb_state_t;

  typedef logic [1:0] gnt_id_t;

  localparam gnt_id_t GNT_IC    = 2'd0;
  localparam gnt_id_t GNT_DC_RD = 2'd1;
  localparam gnt_id_t GNT_DC_WR = 2'd2;

endpackage

// File: rtl/mem_bus_arbiter_rd_pick.sv
// arb_rd_pick: picks the refill winner between ICache and DCache.
// ARB_RR_EN: round-robin on ties via r_last_rd; else DCache wins.
// Ports: i_ic_valid/i_dc_valid requests, o_any, o_pick_dc;
// clk/rstn/i_take (read grant taken) only with ARB_RR_EN.
module arb_rd_pick (
`ifdef ARB_RR_EN
  input  logic clk,
  input  logic rstn,
  input  logic i_take,
`endif
  input  logic i_ic_valid,
  input  logic i_dc_valid,
  output logic o_any,
  output logic o_pick_dc
);

  assign o_any = i_ic_valid || i_dc_valid;

`ifdef ARB_RR_EN
  // 1 = DCache refill was served last
  logic r_last_rd;

  assign o_pick_dc = i_dc_valid &&
                     (!i_ic_valid || !r_last_rd);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last_rd <= 1'b0;
    end else if (i_take) begin
      r_last_rd <= o_pick_dc;
    end
  end
`else
  assign o_pick_dc = i_dc_valid;
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between ICache refill,
// DCache refill and DCache writeback; one burst in flight.
// Ports: ic_rd_*/dc_rd_*/dc_wr_* requester side, ret_data shared
// read return, mem_rd_*/mem_rdata_*/mem_wr_*/mem_wdata_* bridge.
// ARB_RR_EN selects round-robin between the two refills.
module mem_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = mem_bus_arbiter_pkg::LINE_WORDS
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         ic_rd_valid,
  output logic                         ic_rd_ready,
  input  logic [ADDR_W-1:0]            ic_rd_addr,
  output logic                         ic_ret_valid,
  output logic                         ic_ret_last,
  input  logic                         dc_rd_valid,
  output logic                         dc_rd_ready,
  input  logic [ADDR_W-1:0]            dc_rd_addr,
  output logic                         dc_ret_valid,
  output logic                         dc_ret_last,
  output logic [DATA_W-1:0]            ret_data,
  input  logic                         dc_wr_valid,
  output logic                         dc_wr_ready,
  input  logic [ADDR_W-1:0]            dc_wr_addr,
  input  logic [LINE_WORDS*DATA_W-1:0] dc_wr_line,
  output logic                         dc_wr_done,
  output logic                         mem_rd_valid,
  input  logic                         mem_rd_ready,
  output logic [ADDR_W-1:0]            mem_rd_addr,
  input  logic                         mem_rdata_valid,
  input  logic                         mem_rdata_last,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic                         mem_wr_valid,
  input  logic                         mem_wr_ready,
  output logic [ADDR_W-1:0]            mem_wr_addr,
  output logic                         mem_wdata_valid,
  input  logic                         mem_wdata_ready,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic                         mem_wdata_last,
  input  logic                         mem_wr_resp
);
  import mem_bus_arbiter_pkg::*;

  localparam int BW = $clog2(LINE_WORDS);

  arb_state_t        r_state;
  gnt_id_t           r_gnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_line [LINE_WORDS];
  logic [BW-1:0]     r_beat;
  logic              r_wr_done;

  logic w_idle;
  logic w_rd_any;
  logic w_pick_dc;
  logic w_wr_gnt;
  logic w_rd_gnt;
  logic w_rd_data;
  logic w_wdata_hs;

  assign w_idle   = (r_state == IDLE);
  assign w_wr_gnt = w_idle && dc_wr_valid;
  assign w_rd_gnt = w_idle && !dc_wr_valid && w_rd_any;

  arb_rd_pick u_rd_pick (
`ifdef ARB_RR_EN
    .clk       (clk),
    .rstn      (rstn),
    .i_take    (w_rd_gnt),
`endif
    .i_ic_valid(ic_rd_valid),
    .i_dc_valid(dc_rd_valid),
    .o_any     (w_rd_any),
    .o_pick_dc (w_pick_dc)
  );

  assign ic_rd_ready = w_rd_gnt && !w_pick_dc;
  assign dc_rd_ready = w_rd_gnt && w_pick_dc;
  assign dc_wr_ready = w_wr_gnt;

  // read return is a zero-latency pass-through to the owner
  assign w_rd_data    = (r_state == RD_DATA);
  assign ic_ret_valid = w_rd_data && (r_gnt == GNT_IC) &&
                        mem_rdata_valid;
  assign ic_ret_last  = w_rd_data && (r_gnt == GNT_IC) &&
                        mem_rdata_last;
  assign dc_ret_valid = w_rd_data && (r_gnt == GNT_DC_RD) &&
                        mem_rdata_valid;
  assign dc_ret_last  = w_rd_data && (r_gnt == GNT_DC_RD) &&
                        mem_rdata_last;
  assign ret_data     = w_rd_data ? mem_rdata : '0;

  assign mem_rd_valid    = (r_state == RD_REQ);
  assign mem_rd_addr     = r_addr;
  assign mem_wr_valid    = (r_state == WR_REQ);
  assign mem_wr_addr     = r_addr;
  assign mem_wdata_valid = (r_state == WR_DATA);
  assign mem_wdata       = r_line[r_beat];
  assign mem_wdata_last  = mem_wdata_valid && (&r_beat);
  assign dc_wr_done      = r_wr_done;

  assign w_wdata_hs = mem_wdata_valid && mem_wdata_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_gnt     <= GNT_IC;
      r_addr    <= '0;
      r_beat    <= '0;
      r_wr_done <= 1'b0;
      for (int i = 0; i < LINE_WORDS; i++) begin
        r_line[i] <= '0;
      end
    end else begin
      r_wr_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_wr_gnt) begin
            r_state <= WR_REQ;
            r_gnt   <= GNT_DC_WR;
            r_addr  <= dc_wr_addr;
            for (int i = 0; i < LINE_WORDS; i++) begin
              r_line[i] <= dc_wr_line[i*DATA_W +: DATA_W];
            end
          end else if (w_rd_gnt) begin
            r_state <= RD_REQ;
            r_gnt   <= w_pick_dc ? GNT_DC_RD : GNT_IC;
            r_addr  <= w_pick_dc ? dc_rd_addr : ic_rd_addr;
          end
        end
        RD_REQ: begin
          if (mem_rd_ready) r_state <= RD_DATA;
        end
        RD_DATA: begin
          if (mem_rdata_valid && mem_rdata_last) begin
            r_state <= IDLE;
          end
        end
        WR_REQ: begin
          if (mem_wr_ready) begin
            r_state <= WR_DATA;
            r_beat  <= '0;
          end
        end
        WR_DATA: begin
          if (w_wdata_hs) begin
            r_beat <= r_beat + BW'(1);
            if (&r_beat) r_state <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (mem_wr_resp) begin
            r_wr_done <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
